// File: rtl/onehot_encoder_stream.sv
// ---------------------------------------------------------------------------
// onehot_encoder_stream
//
// Streaming one-hot to binary encoder. A word offered on the input
// valid/ready handshake is encoded and held in a single registered result
// slot until the consumer takes it. A word that cannot be encoded raises
// out_err and bumps a saturating diagnostic counter.
//
// Parameters:
//   N_IN      - number of one-hot input lines (>= 2)
//   CODE_W    - encoded index width, derived from N_IN (do not override)
//   ERR_CNT_W - width of the saturating error counter
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   in_data carries a word
//   in_data    in   one-hot word, bit 0 is the first line
//   in_ready   out  a word can be accepted this cycle
//   out_valid  out  result slot is occupied
//   out_ready  in   consumer takes the result this cycle
//   out_code   out  index of the set bit (0 when out_err)
//   out_err    out  word was not encodable
//   err_clr    in   clear err_count
//   err_count  out  saturating count of accepted erroneous words
//
// Build option:
//   ONEHOT_PRIORITY_EN - when defined, a multi-hot word encodes as its
//   lowest set bit with no error; a zero word is still an error. When
//   undefined, any word without exactly one set bit is an error.
// ---------------------------------------------------------------------------
module onehot_encoder_stream #(
   parameter int N_IN      = 4,
   parameter int CODE_W    = $clog2(N_IN),
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [N_IN-1:0]      in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CODE_W-1:0]    out_code,
   output logic                 out_err,
   input  logic                 err_clr,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_nxt;

   logic                   accept_p0;
   logic [CODE_W-1:0]      code_p0;
   logic                   err_p0;

   logic [CODE_W-1:0]      code_p1;
   logic                   err_p1;
   logic [ERR_CNT_W-1:0]   cnt_p1;

   // Lowest-index set bit; scanning downward lets the last hit win.
   function automatic logic [CODE_W-1:0] lowest_index(input logic [N_IN-1:0] w);
      logic [CODE_W-1:0] idx;
      idx = '0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         if (w[i]) idx = CODE_W'(i);
      end
      return idx;
   endfunction

`ifdef ONEHOT_PRIORITY_EN
   function automatic logic encode_err(input logic [N_IN-1:0] w);
      return (w == '0);
   endfunction
`else
   // Clearing the lowest set bit leaves a nonzero word only if two or
   // more bits were set.
   function automatic logic is_multi(input logic [N_IN-1:0] w);
      return ((w & (w - N_IN'(1))) != '0);
   endfunction

   function automatic logic encode_err(input logic [N_IN-1:0] w);
      return (w == '0) || is_multi(w);
   endfunction
`endif

   function automatic logic [CODE_W-1:0] encode_code(input logic [N_IN-1:0] w);
      return encode_err(w) ? '0 : lowest_index(w);
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
      return (&c) ? c : c + ERR_CNT_W'(1);
   endfunction

   // ---- stage p0: handshake and combinational encode of the offered word
   assign accept_p0 = in_valid && in_ready;
   assign code_p0   = encode_code(in_data);
   assign err_p0    = encode_err(in_data);

   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (accept_p0) state_nxt = FULL;
         FULL:  if (out_ready && !in_valid) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // in_ready looks only at the slot state and out_ready, so there is no
   // path from in_data to any output.
   always_comb begin
      out_valid = (state == FULL);
      in_ready  = (state == EMPTY) || out_ready;
   end

   // ---- stage p1: registered result slot and error counter
   always_ff @(posedge clk) begin
      if (rst) begin
         code_p1 <= '0;
         err_p1  <= 1'b0;
      end else if (accept_p0) begin
         code_p1 <= code_p0;
         err_p1  <= err_p0;
      end
   end

   // A clear coinciding with an erroneous accept counts that word, so the
   // counter restarts at 1 rather than losing the event.
   always_ff @(posedge clk) begin
      if (rst)                          cnt_p1 <= '0;
      else if (err_clr && accept_p0 && err_p0) cnt_p1 <= ERR_CNT_W'(1);
      else if (err_clr)                 cnt_p1 <= '0;
      else if (accept_p0 && err_p0)     cnt_p1 <= sat_inc(cnt_p1);
   end

   assign out_code  = code_p1;
   assign out_err   = err_p1;
   assign err_count = cnt_p1;

endmodule

// File: tb/tb_onehot_encoder_stream.sv
module tb_onehot_encoder_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // main instance: N_IN=4, ERR_CNT_W=8
   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err, a_err_clr;
   logic [3:0] a_in_data;
   logic [1:0] a_out_code;
   logic [7:0] a_err_count;

   // saturation instance: N_IN=4, ERR_CNT_W=2
   logic       s_in_valid, s_in_ready, s_out_valid, s_out_err, s_err_clr;
   logic [3:0] s_in_data;
   logic [1:0] s_out_code;
   logic [1:0] s_err_count;

   // N_IN=8 instance
   logic       e_in_valid, e_in_ready, e_out_valid, e_out_err;
   logic [7:0] e_in_data;
   logic [2:0] e_out_code;
   logic [7:0] e_err_count;

   // N_IN=5 instance
   logic       f_in_valid, f_in_ready, f_out_valid, f_out_err;
   logic [4:0] f_in_data;
   logic [2:0] f_out_code;
   logic [7:0] f_err_count;

   int n_vec = 0;
   int n_bad = 0;

   // reference model of the main instance
   bit r_full;
   int r_code;
   bit r_err;
   int r_cnt;

   logic [12:0] a_obs;
   assign a_obs = {a_out_valid, a_in_ready, a_out_err, a_out_code, a_err_count};

   onehot_encoder_stream #(.N_IN(4), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
      .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_code(a_out_code), .out_err(a_out_err), .err_clr(a_err_clr),
      .err_count(a_err_count));

   onehot_encoder_stream #(.N_IN(4), .ERR_CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_data(s_in_data),
      .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(1'b1),
      .out_code(s_out_code), .out_err(s_out_err), .err_clr(s_err_clr),
      .err_count(s_err_count));

   onehot_encoder_stream #(.N_IN(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_data(e_in_data),
      .in_ready(e_in_ready), .out_valid(e_out_valid), .out_ready(1'b1),
      .out_code(e_out_code), .out_err(e_out_err), .err_clr(1'b0),
      .err_count(e_err_count));

   onehot_encoder_stream #(.N_IN(5)) dut5 (
      .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_data(f_in_data),
      .in_ready(f_in_ready), .out_valid(f_out_valid), .out_ready(1'b1),
      .out_code(f_out_code), .out_err(f_out_err), .err_clr(1'b0),
      .err_count(f_err_count));

   // Encoding rule straight from the definition: a power of two maps to
   // its log2; anything else is an error (or, in the priority build, the
   // isolated lowest set bit is taken).
   function automatic void ref_encode(input logic [31:0] w, output int code, output bit err);
`ifdef ONEHOT_PRIORITY_EN
      logic [31:0] low;
      low = w & (~w + 32'd1);
`endif
      code = 0;
      err  = 1'b0;
      if (w == 32'd0) err = 1'b1;
`ifdef ONEHOT_PRIORITY_EN
      else code = $clog2(low);
`else
      else if ($countones(w) > 1) err = 1'b1;
      else code = $clog2(w);
`endif
   endfunction

   // Apply one cycle of inputs to the main instance and advance the model.
   task automatic cyc(input logic r, input logic iv, input logic [3:0] d,
                      input logic ordy, input logic eclr);
      int  c;
      bit  e;
      bit  acc;
      rst = r; a_in_valid = iv; a_in_data = d; a_out_ready = ordy; a_err_clr = eclr;
      @(posedge clk);
      if (r) begin
         r_full = 1'b0; r_code = 0; r_err = 1'b0; r_cnt = 0;
      end else begin
         acc = iv && (!r_full || ordy);
         ref_encode({28'd0, d}, c, e);
         if (eclr) r_cnt = (acc && e) ? 1 : 0;
         else if (acc && e && r_cnt < 255) r_cnt = r_cnt + 1;
         if (acc) begin
            r_full = 1'b1; r_code = c; r_err = e;
         end else if (ordy) r_full = 1'b0;
      end
      @(negedge clk);
   endtask

   function automatic logic [12:0] model_vec();
      return {r_full, (!r_full || a_out_ready), r_err, 2'(r_code), 8'(r_cnt)};
   endfunction

   task automatic test_reset();
      cyc(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 4'b0100, 1'b1, 1'b1);
      n_vec++;
      if (a_obs !== 13'b0_1_0_00_00000000) begin
         n_bad++; $display("FAIL reset_main obs=%b req=%b", a_obs, 13'b0_1_0_00_00000000);
      end
      n_vec++;
      if ({s_out_valid, s_err_count, e_out_valid, f_out_valid} !== 5'b0) begin
         n_bad++; $display("FAIL reset_others obs=%b req=00000",
                           {s_out_valid, s_err_count, e_out_valid, f_out_valid});
      end
   endtask

   task automatic test_onehot_seq();
      logic [12:0] req;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 4'(1 << i), 1'b1, 1'b0);
         req = {1'b1, 1'b1, 1'b0, 2'(i), 8'd0};
         n_vec++;
         if (a_obs !== req || a_obs !== model_vec()) begin
            n_bad++; $display("FAIL onehot_seq[%0d] obs=%b req=%b", i, a_obs, req);
         end
      end
      // idle cycle with junk data: slot empties, code holds
      cyc(1'b0, 1'b0, 4'b1111, 1'b1, 1'b0);
      n_vec++;
      if (a_obs !== 13'b0_1_0_11_00000000) begin
         n_bad++; $display("FAIL onehot_idle obs=%b req=%b", a_obs, 13'b0_1_0_11_00000000);
      end
   endtask

   task automatic test_errors();
      logic [12:0] req;
      cyc(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0);
      n_vec++;
      if (a_obs !== 13'b1_1_1_00_00000001) begin
         n_bad++; $display("FAIL err_zero obs=%b req=%b", a_obs, 13'b1_1_1_00_00000001);
      end
      cyc(1'b0, 1'b1, 4'b0101, 1'b1, 1'b0);
`ifdef ONEHOT_PRIORITY_EN
      req = 13'b1_1_0_00_00000001;
`else
      req = 13'b1_1_1_00_00000010;
`endif
      n_vec++;
      if (a_obs !== req || a_obs !== model_vec()) begin
         n_bad++; $display("FAIL err_multi obs=%b req=%b", a_obs, req);
      end
      cyc(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
   endtask

   task automatic test_backpressure();
      logic [12:0] req;
      cyc(1'b0, 1'b1, 4'b0100, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0);
         req = {1'b1, 1'b0, 1'b0, 2'd2, 8'(r_cnt)};
         n_vec++;
         if (a_obs !== req) begin
            n_bad++; $display("FAIL backpressure_hold[%0d] obs=%b req=%b", k, a_obs, req);
         end
      end
      cyc(1'b0, 1'b1, 4'b1000, 1'b1, 1'b0);
      req = {1'b1, 1'b1, 1'b0, 2'd3, 8'(r_cnt)};
      n_vec++;
      if (a_obs !== req) begin
         n_bad++; $display("FAIL backpressure_release obs=%b req=%b", a_obs, req);
      end
   endtask

   task automatic test_reset_mid();
      cyc(1'b0, 1'b1, 4'b0010, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
      n_vec++;
      if (a_obs !== {1'b1, 1'b0, 1'b0, 2'd1, 8'(r_cnt)} || r_cnt == 0) begin
         n_bad++; $display("FAIL reset_mid_pre obs=%b req=%b", a_obs,
                           {1'b1, 1'b0, 1'b0, 2'd1, 8'(r_cnt)});
      end
      cyc(1'b1, 1'b1, 4'b1000, 1'b0, 1'b0);
      n_vec++;
      if (a_obs !== 13'b0_1_0_00_00000000) begin
         n_bad++; $display("FAIL reset_mid obs=%b req=%b", a_obs, 13'b0_1_0_00_00000000);
      end
      cyc(1'b0, 1'b1, 4'b1000, 1'b1, 1'b0);
      n_vec++;
      if (a_obs !== 13'b1_1_0_11_00000000) begin
         n_bad++; $display("FAIL reset_mid_after obs=%b req=%b", a_obs, 13'b1_1_0_11_00000000);
      end
      cyc(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
   endtask

   task automatic test_saturation();
      int req;
      for (int k = 0; k < 5; k++) begin
         s_in_valid = 1'b1; s_in_data = 4'b0000; s_err_clr = 1'b0;
         @(posedge clk); @(negedge clk);
         req = (k + 1 > 3) ? 3 : k + 1;
         n_vec++;
         if (s_err_count !== 2'(req) || s_out_err !== 1'b1) begin
            n_bad++; $display("FAIL sat_count[%0d] obs=%0d req=%0d", k, s_err_count, req);
         end
      end
      s_err_clr = 1'b1;
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (s_err_count !== 2'd1) begin
         n_bad++; $display("FAIL sat_clr_with_err obs=%0d req=1", s_err_count);
      end
      s_in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (s_err_count !== 2'd0) begin
         n_bad++; $display("FAIL sat_clr_alone obs=%0d req=0", s_err_count);
      end
      s_err_clr = 1'b0; s_in_valid = 1'b1; s_in_data = 4'b0010;
      @(posedge clk); @(negedge clk);
      n_vec++;
      if ({s_out_valid, s_in_ready, s_out_err, s_out_code, s_err_count} !== 7'b1_1_0_01_00) begin
         n_bad++; $display("FAIL sat_good_word obs=%b req=1100100",
                           {s_out_valid, s_in_ready, s_out_err, s_out_code, s_err_count});
      end
      s_in_valid = 1'b0;
   endtask

   task automatic test_sweep();
      int  c;
      bit  e;
      logic [7:0] w8;
      logic [4:0] w5;
      e_in_valid = 1'b1; e_in_data = 8'b1000_0000;
      f_in_valid = 1'b1; f_in_data = 5'b10000;
      @(posedge clk); @(negedge clk);
      n_vec++;
      if ({e_out_valid, e_out_err, e_out_code} !== 5'b1_0_111) begin
         n_bad++; $display("FAIL sweep_n8 obs=%b req=10111", {e_out_valid, e_out_err, e_out_code});
      end
      n_vec++;
      if ({f_out_valid, f_out_err, f_out_code} !== 5'b1_0_100) begin
         n_bad++; $display("FAIL sweep_n5 obs=%b req=10100", {f_out_valid, f_out_err, f_out_code});
      end
      for (int k = 0; k < 16; k++) begin
         w8 = ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
         w5 = ($urandom_range(0, 1) == 1) ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom);
         e_in_data = w8; f_in_data = w5;
         @(posedge clk); @(negedge clk);
         ref_encode({24'd0, w8}, c, e);
         n_vec++;
         if ({e_out_valid, e_in_ready, e_out_err, e_out_code} !== {1'b1, 1'b1, e, 3'(c)}) begin
            n_bad++; $display("FAIL sweep_rand_n8 in=%b obs=%b req=%b", w8,
                              {e_out_valid, e_in_ready, e_out_err, e_out_code}, {1'b1, 1'b1, e, 3'(c)});
         end
         ref_encode({27'd0, w5}, c, e);
         n_vec++;
         if ({f_out_valid, f_in_ready, f_out_err, f_out_code} !== {1'b1, 1'b1, e, 3'(c)}) begin
            n_bad++; $display("FAIL sweep_rand_n5 in=%b obs=%b req=%b", w5,
                              {f_out_valid, f_in_ready, f_out_err, f_out_code}, {1'b1, 1'b1, e, 3'(c)});
         end
      end
      n_vec++;
      if (e_err_count === 8'd0 && f_err_count === 8'd0) begin
         n_bad++; $display("FAIL sweep_err_count obs=%0d/%0d req=nonzero", e_err_count, f_err_count);
      end
      e_in_valid = 1'b0; f_in_valid = 1'b0;
   endtask

   task automatic test_random();
      logic       r, iv, ordy, eclr;
      logic [3:0] d;
      for (int k = 0; k < 400; k++) begin
         r    = ($urandom_range(0, 39) == 0);
         iv   = ($urandom_range(0, 3) != 0);
         d    = ($urandom_range(0, 1) == 1) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
         ordy = ($urandom_range(0, 9) < 7);
         eclr = ($urandom_range(0, 15) == 0);
         cyc(r, iv, d, ordy, eclr);
         n_vec++;
         if (a_obs !== model_vec()) begin
            n_bad++; $display("FAIL random[%0d] obs=%b req=%b", k, a_obs, model_vec());
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      a_in_valid = 1'b0; a_in_data = 4'b0; a_out_ready = 1'b1; a_err_clr = 1'b0;
      s_in_valid = 1'b0; s_in_data = 4'b0; s_err_clr = 1'b0;
      e_in_valid = 1'b0; e_in_data = 8'b0;
      f_in_valid = 1'b0; f_in_data = 5'b0;
      r_full = 1'b0; r_code = 0; r_err = 1'b0; r_cnt = 0;
      @(negedge clk);
      test_reset();
      test_onehot_seq();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_saturation();
      test_sweep();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
